// File: rtl/sled_pkg.sv
// Shared definitions for the serial LED chain driver: FSM states, default
// parameters and the frame-length helper.
package sled_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_CHAINS    = 2;
    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_MSB_FIRST = 1;

    // Cycles from the first SHIFT cycle to the end of the latch pulse.
    function automatic int frame_cycles(input int n_bits, input int clk_div);
        return (2 * n_bits + 1) * clk_div;
    endfunction

endpackage

// File: rtl/sled_clkgen.sv
// Phase counter for the serial clock: CLK_DIV cycles per half-period, with
// strobes marking the end of each half, the end of a bit and the cycle before a half ends.
module sled_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic sclk_o,
    output logic half_end_o,
    output logic bit_end_o,
    output logic pre_end_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_PRE  = (CLK_DIV > 1) ? PW'(CLK_DIV - 2) : '0;

    logic [PW-1:0] phase_q, phase_d;
    logic          half_q, half_d;

    always_comb begin
        phase_d = phase_q;
        half_d  = half_q;
        if (clr_i) begin
            phase_d = '0;
            half_d  = 1'b0;
        end else if (en_i) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                half_d  = ~half_q;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            half_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            half_q  <= half_d;
        end
    end

    // half_q is the registered serial clock itself: low half first, then high.
    assign sclk_o     = half_q;
    assign half_end_o = en_i && (phase_q == PH_LAST);
    assign bit_end_o  = half_end_o && half_q;
    assign pre_end_o  = en_i && (CLK_DIV > 1) && (phase_q == PH_PRE);

endmodule

// File: rtl/sled_chain.sv
// Serial driver for daisy-chained LED shift-register devices: shifts an N-bit
// pattern out on sout/sclk, then pulses slatch; one pattern can wait in a pending buffer.
module sled_chain
    import sled_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHAINS    = DEF_CHAINS,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH*CHAINS-1:0]   data_in,
    input  logic                      load,
    output logic                      ready,
    output logic                      sout,
    output logic                      sclk,
    output logic                      slatch,
    output logic                      busy,
    output logic                      done
);

    localparam int N  = WIDTH * CHAINS;
    localparam int CW = $clog2(N + 1);

    state_t          state_q, state_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [N-1:0]    pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sout_q, slatch_q, busy_q, done_q, ready_q;
    logic            sout_d, slatch_d, busy_d, done_d, ready_d;
    logic            accept, gen_en, gen_clr;
    logic            sclk_w, half_end, bit_end, pre_end;

    function automatic logic first_bit(input logic [N-1:0] v);
        return (MSB_FIRST != 0) ? v[N-1] : v[0];
    endfunction

    assign accept  = load && ready_q;
    assign gen_en  = (state_q != IDLE);
    assign gen_clr = (state_q == IDLE) || ((state_q == LATCH) && half_end);

    sled_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (gen_en),
        .clr_i      (gen_clr),
        .sclk_o     (sclk_w),
        .half_end_o (half_end),
        .bit_end_o  (bit_end),
        .pre_end_o  (pre_end)
    );

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    pend_d     = data_in;
                    pend_vld_d = 1'b1;
                end
                if (bit_end) begin
                    sr_d  = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_d = LATCH;
                end
            end
            LATCH: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        sr_d       = pend_q;
                        pend_vld_d = 1'b0;
                        state_d    = SHIFT;
                    end else if (accept) begin
                        // A load landing on the final latch cycle goes straight into the shifter.
                        sr_d    = data_in;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    pend_d     = data_in;
                    pend_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d  = !pend_vld_d && !(accept && (state_q != IDLE));
        sout_d   = (state_d == SHIFT) && first_bit(sr_d);
        slatch_d = (state_d == LATCH);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == LATCH) && ((CLK_DIV == 1) || ((state_q == LATCH) && pre_end));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            sout_q     <= 1'b0;
            slatch_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            sout_q     <= sout_d;
            slatch_q   <= slatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign sout   = sout_q;
    assign sclk   = sclk_w;
    assign slatch = slatch_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sled_chain.sv
// Scoreboard bench for sled_chain: one MSB-first CLK_DIV=4 instance and one
// LSB-first CLK_DIV=1 instance, serial output reassembled on sclk rises.
module tb_sled_chain;

    localparam int N      = 32;
    localparam int DIV0   = 4;
    localparam int DIV1   = 1;
    localparam int FRAME0 = (2 * N + 1) * DIV0;
    localparam int FRAME1 = (2 * N + 1) * DIV1;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] data0, data1;
    logic load0, load1;
    logic ready0, sout0, sclk0, slatch0, busy0, done0;
    logic ready1, sout1, sclk1, slatch1, busy1, done1;

    always #5 clk = ~clk;

    sled_chain #(.WIDTH(16), .CHAINS(2), .CLK_DIV(DIV0), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data0), .load(load0), .ready(ready0),
        .sout(sout0), .sclk(sclk0), .slatch(slatch0), .busy(busy0), .done(done0)
    );

    sled_chain #(.WIDTH(16), .CHAINS(2), .CLK_DIV(DIV1), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .load(load1), .ready(ready1),
        .sout(sout1), .sclk(sclk1), .slatch(slatch1), .busy(busy1), .done(done1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] q0[$];
    logic [N-1:0] q1[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitor, instance 0 (MSB first) ----------------
    int cyc = 0;
    logic [N-1:0] sh0;
    int nb0 = 0, first_rise0 = 0, lat_len0 = 0, latches0 = 0, dones0 = 0;
    int busy_len0 = 0, run_frames0 = 0;
    logic sclk0_p = 1'b0, slatch0_p = 1'b0, busy0_p = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                nb0 = 0; sh0 = '0; lat_len0 = 0; busy_len0 = 0; run_frames0 = 0;
                sclk0_p = 1'b0; slatch0_p = 1'b0; busy0_p = 1'b0;
            end else begin
                if (sclk0 && !sclk0_p) begin
                    if (nb0 == 0) first_rise0 = cyc;
                    sh0 = {sh0[N-2:0], sout0};
                    nb0++;
                end
                if (slatch0 && !slatch0_p) begin
                    chk("bits0", nb0, N);
                    chk("lat_time0", cyc - first_rise0, 2 * DIV0 * N - DIV0);
                    chk("sb_depth0", q0.size() > 0, 1);
                    if (q0.size() > 0) chk("word0", sh0, q0.pop_front());
                    nb0 = 0;
                    lat_len0 = 0;
                    latches0++;
                end
                if (slatch0) begin
                    lat_len0++;
                    chk("latch_io0", {sout0, sclk0}, 2'b00);
                end
                if (done0) begin
                    dones0++;
                    run_frames0++;
                    chk("done_pos0", {slatch0, lat_len0 == DIV0}, 2'b11);
                end
                if (!slatch0 && slatch0_p) chk("lat_len0", lat_len0, DIV0);
                if (busy0) busy_len0++;
                if (!busy0 && busy0_p) begin
                    chk("frame_len0", busy_len0, run_frames0 * FRAME0);
                    busy_len0 = 0;
                    run_frames0 = 0;
                end
                sclk0_p = sclk0; slatch0_p = slatch0; busy0_p = busy0;
            end
        end
    end

    // ---------------- monitor, instance 1 (LSB first) ----------------
    logic [N-1:0] sh1;
    int nb1 = 0, dones1 = 0, busy_len1 = 0, run_frames1 = 0;
    logic sclk1_p = 1'b0, slatch1_p = 1'b0, busy1_p = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb1 = 0; sh1 = '0; busy_len1 = 0; run_frames1 = 0;
                sclk1_p = 1'b0; slatch1_p = 1'b0; busy1_p = 1'b0;
            end else begin
                if (sclk1 && !sclk1_p) begin
                    if (nb1 == 0 && q1.size() > 0) chk("first_bit1", sout1, q1[0][0]);
                    sh1 = {sout1, sh1[N-1:1]};
                    nb1++;
                end
                if (slatch1 && !slatch1_p) begin
                    chk("bits1", nb1, N);
                    chk("sb_depth1", q1.size() > 0, 1);
                    if (q1.size() > 0) chk("word1", sh1, q1.pop_front());
                    nb1 = 0;
                end
                if (done1) begin
                    dones1++;
                    run_frames1++;
                end
                if (busy1) busy_len1++;
                if (!busy1 && busy1_p) begin
                    chk("frame_len1", busy_len1, run_frames1 * FRAME1);
                    busy_len1 = 0;
                    run_frames1 = 0;
                end
                sclk1_p = sclk1; slatch1_p = slatch1; busy1_p = busy1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_load0(input logic [N-1:0] d, input logic exp_rdy);
        data0 = d;
        load0 = 1'b1;
        chk("ready0", ready0, exp_rdy);
        if (ready0) q0.push_back(d);
        @(negedge clk);
        load0 = 1'b0;
    endtask

    task automatic do_load1(input logic [N-1:0] d);
        data1 = d;
        load1 = 1'b1;
        chk("ready1", ready1, 1'b1);
        if (ready1) q1.push_back(d);
        @(negedge clk);
        load1 = 1'b0;
    endtask

    task automatic wait_done0(input int target);
        for (int i = 0; i < 4000 && dones0 < target; i++) @(negedge clk);
        chk("done_cnt0", dones0, target);
        repeat (3) @(negedge clk);
    endtask

    int lat_before, done_before, acc;
    bit reached;

    initial begin
        rst_n = 1'b0;
        load0 = 1'b0; data0 = '0;
        load1 = 1'b0; data1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_out0", {sout0, sclk0, slatch0, busy0, done0, ready0}, 6'b000001);
        chk("rst_out1", {sout1, sclk1, slatch1, busy1, done1, ready1}, 6'b000001);

        // First load right after reset release, MSB-first reference frame.
        #2 rst_n = 1'b1;
        do_load0(32'hA5A5_0F0F, 1'b1);
        chk("busy_first", busy0, 1'b1);
        wait_done0(1);
        chk("idle_out0", {sout0, sclk0, slatch0, busy0, ready0}, 5'b00001);

        // LSB-first, single-cycle half periods.
        do_load1(32'h0000_0001);
        for (int i = 0; i < 200 && dones1 < 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_cnt1", dones1, 1);

        // Mid-frame load to pending, then a load while pending is full.
        do_load0(32'h1111_1111, 1'b1);
        repeat (50) @(negedge clk);
        do_load0(32'h2222_2222, 1'b1);
        chk("ready_drop", ready0, 1'b0);
        repeat (5) @(negedge clk);
        do_load0(32'h3333_3333, 1'b0);
        wait_done0(3);
        chk("sb_left_a", q0.size(), 0);

        // Load on the final latch cycle with pending empty.
        do_load0(32'hDEAD_BEEF, 1'b1);
        repeat (FRAME0 - 1) @(negedge clk);
        chk("final_latch", {slatch0, done0}, 2'b11);
        do_load0(32'h0BAD_F00D, 1'b1);
        chk("ready_bypass", ready0, 1'b0);
        chk("busy_b2b", busy0, 1'b1);
        @(negedge clk);
        chk("ready_back", ready0, 1'b1);
        wait_done0(5);

        // Asynchronous reset in the middle of bit 10.
        do_load0(32'hCAFE_1234, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (nb0 >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        chk("bit10_wait", reached, 1'b1);
        lat_before = latches0;
        done_before = dones0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {sout0, sclk0, slatch0, busy0, done0, ready0}, 6'b000001);
        q0.delete();
        repeat (3) @(negedge clk);
        chk("no_latch", latches0, lat_before);
        chk("no_done", dones0, done_before);
        #2 rst_n = 1'b1;
        do_load0(32'h5A5A_C3C3, 1'b1);
        wait_done0(done_before + 1);

        // Load held high across ten accepted patterns.
        done_before = dones0;
        lat_before = latches0;
        acc = 0;
        for (int i = 0; i < 5000 && acc < 10; i++) begin
            data0 = 32'h9E37_79B9 * (acc + 1);
            load0 = 1'b1;
            if (ready0) begin
                q0.push_back(data0);
                acc++;
            end
            @(negedge clk);
        end
        load0 = 1'b0;
        chk("accepts", acc, 10);
        wait_done0(done_before + 10);
        chk("latches_10", latches0 - lat_before, 10);
        chk("sb_left_b", q0.size(), 0);
        chk("end_idle0", {busy0, ready0}, 2'b01);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
